// File: rtl/cla_pipe_addsub.sv
// rtl/cla_pipe_addsub.sv - pipelined carry-lookahead adder/subtractor, one lookahead group per stage
module cla_pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int GROUP = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_c,
    output logic             out_v,
    output logic             out_z,
    output logic             out_n
);
    localparam int STAGES = WIDTH / GROUP;

    logic             advance;
    logic [WIDTH-1:0] b_cond;
    logic             c0;

    // Subtract is A + ~B + c0, so borrow-in inverts the carry seen by group 0
    assign b_cond   = in_sub ? ~in_b : in_b;
    assign c0       = in_cin ^ in_sub;
    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    // Every carry is an independent sum of products of g/p terms and the group carry-in
    function automatic logic [GROUP:0] group_carries(
        input logic [GROUP-1:0] a,
        input logic [GROUP-1:0] b,
        input logic             cin
    );
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             term;
        logic             pchain;
        g    = a & b;
        p    = a | b;
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < GROUP; k++) begin
            term   = 1'b0;
            pchain = 1'b1;
            for (int j = k; j >= 0; j--) begin
                term   = term | (pchain & g[j]);
                pchain = pchain & p[j];
            end
            c[k+1] = term | (pchain & cin);
        end
        return c;
    endfunction

    for (genvar s = 0; s < STAGES; s++) begin : stg
        localparam int UP = WIDTH - (s + 1) * GROUP;
        localparam int LO = (s + 1) * GROUP;

        logic             src_v;
        logic             src_c;
        logic             src_z;
        logic [GROUP-1:0] ga;
        logic [GROUP-1:0] gb;
        logic [GROUP:0]   cc;
        logic [GROUP-1:0] slice;
        logic [LO-1:0]    nxt_sum;

        logic             vld_q;
        logic             cy_q;
        logic             z_q;
        logic [LO-1:0]    sum_q;

        if (s == 0) begin : head
            assign src_v   = in_valid;
            assign ga      = in_a[GROUP-1:0];
            assign gb      = b_cond[GROUP-1:0];
            assign src_c   = c0;
            assign src_z   = 1'b1;
            assign nxt_sum = slice;
        end else begin : body
            assign src_v   = stg[s-1].vld_q;
            assign ga      = stg[s-1].fwd.a_q[GROUP-1:0];
            assign gb      = stg[s-1].fwd.b_q[GROUP-1:0];
            assign src_c   = stg[s-1].cy_q;
            assign src_z   = stg[s-1].z_q;
            assign nxt_sum = {slice, stg[s-1].sum_q};
        end

        assign cc    = group_carries(ga, gb, src_c);
        assign slice = ga ^ gb ^ cc[GROUP-1:0];

        // Data registers only load real beats so outputs stay frozen across bubbles
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                z_q   <= 1'b0;
                sum_q <= '0;
            end else if (advance) begin
                vld_q <= src_v;
                if (src_v) begin
                    cy_q  <= cc[GROUP];
                    z_q   <= src_z & (slice == '0);
                    sum_q <= nxt_sum;
                end
            end
        end

        // Upper operand slices not yet consumed travel alongside the beat
        if (UP > 0) begin : fwd
            logic [UP-1:0] a_src;
            logic [UP-1:0] b_src;
            logic [UP-1:0] a_q;
            logic [UP-1:0] b_q;

            if (s == 0) begin : from_in
                assign a_src = in_a[WIDTH-1:GROUP];
                assign b_src = b_cond[WIDTH-1:GROUP];
            end else begin : from_prev
                assign a_src = stg[s-1].fwd.a_q[UP+GROUP-1:GROUP];
                assign b_src = stg[s-1].fwd.b_q[UP+GROUP-1:GROUP];
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance && src_v) begin
                    a_q <= a_src;
                    b_q <= b_src;
                end
            end
        end

        if (s == STAGES - 1) begin : tail
            logic v_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v_q <= 1'b0;
                end else if (advance && src_v) begin
                    v_q <= cc[GROUP] ^ cc[GROUP-1];
                end
            end
        end
    end

    assign out_valid = stg[STAGES-1].vld_q;
    assign out_sum   = stg[STAGES-1].sum_q;
    assign out_c     = stg[STAGES-1].cy_q;
    assign out_z     = stg[STAGES-1].z_q;
    assign out_v     = stg[STAGES-1].tail.v_q;
    assign out_n     = out_sum[WIDTH-1];
endmodule
